// File: rtl/ec_pkg.sv
// Shared field constants, modular add/sub helpers and FSM encoding for secp256k1 point doubling.
package ec_pkg;

  typedef logic [255:0] fe_t;

  localparam fe_t P_SECP256K1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam fe_t P_MINUS_2   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

  typedef enum logic [3:0] {
    S_LOAD, S_SQ, S_3X, S_2Y, S_INV, S_LAM, S_L2, S_RX, S_RY, S_FIN
  } state_t;

  // Both operands must already be < p.
  function automatic fe_t fe_add(input fe_t a, input fe_t b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_SECP256K1}) s = s - {1'b0, P_SECP256K1};
    return s[255:0];
  endfunction

  function automatic fe_t fe_sub(input fe_t a, input fe_t b);
    logic [256:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[256]) d = d + {1'b0, P_SECP256K1};
    return d[255:0];
  endfunction

endpackage

// File: rtl/ec_point_double_fp_mul.sv
// MSB-first interleaved shift-add modular multiplier: 256 iterations plus one result cycle.
module fp_mul
  import ec_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  input  fe_t  a,
  input  fe_t  b,
  output logic done,
  output logic busy,
  output fe_t  prod
);

  fe_t        a_q, a_d, b_q, b_d, acc_q, acc_d, prod_q, prod_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, last_q, last_d, done_q, done_d;
  fe_t        acc_dbl;

  assign acc_dbl = fe_add(acc_q, acc_q);

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    last_d = last_q;
    done_d = 1'b0;
    if (start && !busy_q) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = 8'd255;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!last_q) begin
        acc_d = b_q[cnt_q] ? fe_add(acc_dbl, a_q) : acc_dbl;
        if (cnt_q == 8'd0) last_d = 1'b1;
        else               cnt_d  = cnt_q - 8'd1;
      end else begin
        // Product is held here until the next start.
        prod_d = acc_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;
  assign prod = prod_q;

endmodule

// File: rtl/ec_point_double.sv
// Affine secp256k1 point doubling R = 2P with one shared modular multiplier and Fermat inversion.
module ec_point_double
  import ec_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  fe_t  Px,
  input  fe_t  Py,
  input  fe_t  Qx,
  input  fe_t  Qy,
  output fe_t  Rx,
  output fe_t  Ry,
  output logic Done
);

  state_t     state_q, state_d;
  fe_t        x_q, x_d, y_q, y_d, t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  fe_t        lam_q, lam_d, rx_q, rx_d, rout_q, rout_d, ryout_q, ryout_d;
  logic [7:0] bit_q, bit_d;
  logic       wait_q, wait_d, inv_mul_q, inv_mul_d, done_q, done_d;
  logic       mul_start, mul_done, mul_busy;
  fe_t        mul_a, mul_b, mul_prod;
  logic       unused_q;

  assign unused_q = ^{Qx, Qy};

  fp_mul u_mul (
    .Clk(Clk), .Reset(Reset), .start(mul_start), .a(mul_a), .b(mul_b),
    .done(mul_done), .busy(mul_busy), .prod(mul_prod)
  );

  always_comb begin
    state_d = state_q;  x_d = x_q;  y_d = y_q;
    t0_d = t0_q;  t1_d = t1_q;  t2_d = t2_q;  t3_d = t3_q;
    lam_d = lam_q;  rx_d = rx_q;  rout_d = rout_q;  ryout_d = ryout_q;
    bit_d = bit_q;  wait_d = wait_q;  inv_mul_d = inv_mul_q;  done_d = done_q;
    mul_a = x_q;
    mul_b = x_q;
    mul_start = 1'b0;

    case (state_q)
      S_SQ:    begin mul_a = x_q;   mul_b = x_q; end
      S_INV:   begin mul_a = t3_q;  mul_b = inv_mul_q ? t2_q : t3_q; end
      S_LAM:   begin mul_a = t1_q;  mul_b = t3_q; end
      S_L2:    begin mul_a = lam_q; mul_b = lam_q; end
      S_RY:    begin mul_a = lam_q; mul_b = fe_sub(x_q, rx_q); end
      default: ;
    endcase

    // Every multiply state issues once, then waits for the done pulse.
    if (state_q inside {S_SQ, S_INV, S_LAM, S_L2, S_RY} && !wait_q && !mul_busy) begin
      mul_start = 1'b1;
      wait_d    = 1'b1;
    end

    case (state_q)
      S_LOAD: begin
        x_d = Px;
        y_d = Py;
        if (Py == '0) begin
          rout_d  = '0;
          ryout_d = '0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_SQ;
        end
      end
      S_SQ: if (wait_q && mul_done) begin
        t0_d = mul_prod; wait_d = 1'b0; state_d = S_3X;
      end
      S_3X: begin
        t1_d    = fe_add(fe_add(t0_q, t0_q), t0_q);
        state_d = S_2Y;
      end
      S_2Y: begin
        t2_d      = fe_add(y_q, y_q);
        t3_d      = fe_t'(1);
        bit_d     = 8'd255;
        inv_mul_d = 1'b0;
        state_d   = S_INV;
      end
      S_INV: if (wait_q && mul_done) begin
        t3_d   = mul_prod;
        wait_d = 1'b0;
        if (!inv_mul_q && P_MINUS_2[bit_q]) begin
          inv_mul_d = 1'b1;
        end else begin
          inv_mul_d = 1'b0;
          if (bit_q == 8'd0) state_d = S_LAM;
          else               bit_d   = bit_q - 8'd1;
        end
      end
      S_LAM: if (wait_q && mul_done) begin
        lam_d = mul_prod; wait_d = 1'b0; state_d = S_L2;
      end
      S_L2: if (wait_q && mul_done) begin
        t0_d = mul_prod; wait_d = 1'b0; state_d = S_RX;
      end
      S_RX: begin
        rx_d    = fe_sub(fe_sub(t0_q, x_q), x_q);
        state_d = S_RY;
      end
      S_RY: if (wait_q && mul_done) begin
        wait_d  = 1'b0;
        rout_d  = rx_q;
        ryout_d = fe_sub(mul_prod, y_q);
        done_d  = 1'b1;
        state_d = S_FIN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_LOAD;
      x_q <= '0;  y_q <= '0;  t0_q <= '0;  t1_q <= '0;  t2_q <= '0;  t3_q <= '0;
      lam_q <= '0;  rx_q <= '0;  rout_q <= '0;  ryout_q <= '0;
      bit_q <= '0;  wait_q <= 1'b0;  inv_mul_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  t0_q <= t0_d;  t1_q <= t1_d;  t2_q <= t2_d;  t3_q <= t3_d;
      lam_q <= lam_d;  rx_q <= rx_d;  rout_q <= rout_d;  ryout_q <= ryout_d;
      bit_q <= bit_d;  wait_q <= wait_d;  inv_mul_q <= inv_mul_d;  done_q <= done_d;
    end
  end

  assign Rx   = rout_q;
  assign Ry   = ryout_q;
  assign Done = done_q;

endmodule

// File: tb/tb_ec_point_double.sv
// Scoreboard bench for ec_point_double plus a direct fp_mul unit check.
module tb_ec_point_double;
  import ec_pkg::*;

  localparam fe_t GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam fe_t GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam fe_t G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam fe_t G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam fe_t G4X = 256'hE493DBF1C10D80F3581E4904930B1404CC6C13900EE0758474FA94ABE8C4CD13;
  localparam fe_t G4Y = 256'h51ED993EA0D455B75642E2098EA51448D967AE33BFBDFE40CFE97BDC47739922;

  typedef struct {
    fe_t   rx;
    fe_t   ry;
    string name;
  } exp_t;

  logic clk, rst_n, done, m_start, m_done, m_busy;
  fe_t  px, py, rx, ry, m_a, m_b, m_prod;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  fe_t  mexp_q[$];
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ec_point_double dut (
    .Clk(clk), .Reset(rst_n), .Px(px), .Py(py), .Qx(px), .Qy(py),
    .Rx(rx), .Ry(ry), .Done(done)
  );

  fp_mul u_mul_tb (
    .Clk(clk), .Reset(rst_n), .start(m_start), .a(m_a), .b(m_b),
    .done(m_done), .busy(m_busy), .prod(m_prod)
  );

  task automatic chk(input string nm, input fe_t act, input fe_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1 && done_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_rx"}, rx, e.rx);
        chk({e.name, "_ry"}, ry, e.ry);
      end
    end
    done_prev = done;
  end

  always @(negedge clk) begin
    if (m_done === 1'b1) begin
      if (mexp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mul_done actual=1 required=0");
      end else begin
        fe_t e;
        e = mexp_q.pop_front();
        chk("mul_prod", m_prod, e);
      end
    end
  end

  task automatic wait_done(input string nm, input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_in_time"}, fe_t'(done), fe_t'(1));
  endtask

  task automatic do_mul(input fe_t a, input fe_t b, input fe_t want);
    int n = 0;
    mexp_q.push_back(want);
    m_a = a;
    m_b = b;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    while (m_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mul_done_in_time", fe_t'(m_done), fe_t'(1));
    @(negedge clk);
  endtask

  task automatic start_run(input fe_t x, input fe_t y);
    @(negedge clk);
    rst_n = 1'b0;
    px = x;
    py = y;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int drops;
    rst_n = 1'b0;
    px = '0;
    py = '0;
    m_start = 1'b0;
    m_a = '0;
    m_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", fe_t'(done), '0);
    chk("reset_rx", rx, '0);
    chk("reset_ry", ry, '0);

    // y = 0: point at infinity handling, immediate finish
    px = fe_t'(5);
    py = '0;
    exp_q.push_back('{rx: '0, ry: '0, name: "py0"});
    rst_n = 1'b1;
    wait_done("py0", 3);

    do_mul(fe_t'(3), fe_t'(5), fe_t'(15));
    do_mul(P_SECP256K1 - fe_t'(1), P_SECP256K1 - fe_t'(1), fe_t'(1));
    do_mul(P_SECP256K1 - fe_t'(1), fe_t'(2), P_SECP256K1 - fe_t'(2));

    // Abort a G doubling partway through the inversion
    start_run(GX, GY);
    repeat (20000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_done", fe_t'(done), '0);
    chk("abort_rx", rx, '0);
    chk("abort_ry", ry, '0);
    @(negedge clk);
    exp_q.push_back('{rx: G2X, ry: G2Y, name: "dbl_G"});
    rst_n = 1'b1;
    wait_done("dbl_G", 200000);

    drops = 0;
    for (int i = 0; i < 100; i++) begin
      px = {8{$urandom}};
      py = {8{$urandom}};
      @(negedge clk);
      if (done !== 1'b1) drops++;
    end
    chk("hold_rx", rx, G2X);
    chk("hold_ry", ry, G2Y);
    chk("hold_done_drops", fe_t'(drops), '0);

    start_run(G2X, G2Y);
    exp_q.push_back('{rx: G4X, ry: G4Y, name: "dbl_2G"});
    wait_done("dbl_2G", 200000);

    repeat (3) @(negedge clk);
    chk("scoreboard_left", fe_t'(exp_q.size()), '0);
    chk("mul_scoreboard_left", fe_t'(mexp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
